sha256_nonce_sequencer: RTL and testbench

- Initiator/controller for the single-block SHA-256 engine: captures a 19-word Bitcoin header and drives the engine's start/message/hash_val/round2 interface.
- Collects engine results and emits one double-SHA-256 h0 word per nonce.
- Midstate (block 1) is computed once per job; blocks 2 and 3 are computed per nonce.
- Sits between the top-level bitcoin_hash memory/control logic and one engine instance.

---
 rtl/sha256_nonce_sequencer_if.sv | 13 +
 rtl/sha256_nonce_sequencer.sv | 154 +++++++++++++++
 tb/tb_sha256_nonce_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_nonce_sequencer_if.sv
// Engine-side bus of the nonce sequencer: block request (start/message/chaining value)
// and the engine's digest response.
interface sha256_nonce_sequencer_if;
    logic              start;
    logic [15:0][31:0] message;
    logic [7:0][31:0]  hash_val;
    logic              round2;
    logic [7:0][31:0]  result;
    logic              done;

    modport master (output start, message, hash_val, round2, input result, done);
    modport slave  (input start, message, hash_val, round2, output result, done);
endinterface

// File: rtl/sha256_nonce_sequencer.sv
// Drives one SHA-256 block engine to produce a double-SHA-256 h0 word per nonce:
// midstate once per job, then blocks 2 and 3 for every nonce 0 .. NUM_NONCES-1.
module sha256_nonce_sequencer #(
    parameter int NUM_NONCES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [18:0][31:0] header,
    output logic              busy,
    output logic              job_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_nonce,
    output logic [31:0]       out_hash,
    sha256_nonce_sequencer_if.master eng
);
    localparam logic [31:0] LAST_NONCE = 32'(NUM_NONCES - 1);
    localparam logic [31:0] PAD_WORD   = 32'h8000_0000;
    localparam logic [31:0] LEN_80B    = 32'h0000_0280;
    localparam logic [31:0] LEN_32B    = 32'h0000_0100;

    typedef enum logic [3:0] {
        IDLE, MID_S, MID_W, B2_S, B2_W, B3_S, B3_W, EMIT, DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [18:0][31:0] header_reg, header_next;
    logic [7:0][31:0]  midstate_reg, midstate_next;
    logic [31:0]       nonce_reg, nonce_next;
    logic [15:0][31:0] message_reg, message_next;
    logic              round2_reg, round2_next;
    logic              eng_start_reg, eng_start_next;
    logic              busy_reg, busy_next;
    logic              job_done_reg, job_done_next;
    logic              out_valid_reg, out_valid_next;
    logic [31:0]       out_nonce_reg, out_nonce_next;
    logic [31:0]       out_hash_reg, out_hash_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = MID_S;
            MID_S:   state_next = MID_W;
            MID_W:   if (eng.done) state_next = B2_S;
            B2_S:    state_next = B2_W;
            B2_W:    if (eng.done) state_next = B3_S;
            B3_S:    state_next = B3_W;
            B3_W:    if (eng.done) state_next = EMIT;
            EMIT:    if (out_ready) state_next = (nonce_reg == LAST_NONCE) ? DONE : B2_S;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // All engine-facing and result outputs are registered from the next state, so a
    // block's message is loaded on the edge that enters its *_S state and then holds.
    always_comb begin
        header_next    = header_reg;
        midstate_next  = midstate_reg;
        nonce_next     = nonce_reg;
        message_next   = message_reg;
        round2_next    = round2_reg;
        out_nonce_next = out_nonce_reg;
        out_hash_next  = out_hash_reg;

        if (state_reg == IDLE && start) begin
            header_next = header;
            nonce_next  = '0;
        end
        if (state_reg == MID_W && eng.done)
            midstate_next = eng.result;
        if (state_reg == EMIT && out_ready && nonce_reg != LAST_NONCE)
            nonce_next = nonce_reg + 32'd1;
        if (state_reg == B3_W && eng.done) begin
            out_hash_next  = eng.result[0];
            out_nonce_next = nonce_reg;
        end

        case (state_next)
            MID_S: begin
                message_next = header[15:0];
                round2_next  = 1'b0;
            end
            B2_S: begin
                message_next     = '0;
                message_next[0]  = header_reg[16];
                message_next[1]  = header_reg[17];
                message_next[2]  = header_reg[18];
                message_next[3]  = nonce_next;
                message_next[4]  = PAD_WORD;
                message_next[15] = LEN_80B;
                round2_next      = 1'b1;
            end
            B3_S: begin
                // Block 3 hashes the first digest directly off the engine result bus.
                message_next       = '0;
                message_next[7:0]  = eng.result;
                message_next[8]    = PAD_WORD;
                message_next[15]   = LEN_32B;
                round2_next        = 1'b0;
            end
            default: ;
        endcase

        eng_start_next = (state_next == MID_S) || (state_next == B2_S) || (state_next == B3_S);
        busy_next      = (state_next != IDLE);
        job_done_next  = (state_next == DONE);
        out_valid_next = (state_next == EMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            header_reg    <= '0;
            midstate_reg  <= '0;
            nonce_reg     <= '0;
            message_reg   <= '0;
            round2_reg    <= 1'b0;
            eng_start_reg <= 1'b0;
            busy_reg      <= 1'b0;
            job_done_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_nonce_reg <= '0;
            out_hash_reg  <= '0;
        end else begin
            header_reg    <= header_next;
            midstate_reg  <= midstate_next;
            nonce_reg     <= nonce_next;
            message_reg   <= message_next;
            round2_reg    <= round2_next;
            eng_start_reg <= eng_start_next;
            busy_reg      <= busy_next;
            job_done_reg  <= job_done_next;
            out_valid_reg <= out_valid_next;
            out_nonce_reg <= out_nonce_next;
            out_hash_reg  <= out_hash_next;
        end
    end

    assign busy         = busy_reg;
    assign job_done     = job_done_reg;
    assign out_valid    = out_valid_reg;
    assign out_nonce    = out_nonce_reg;
    assign out_hash     = out_hash_reg;
    assign eng.start    = eng_start_reg;
    assign eng.message  = message_reg;
    assign eng.hash_val = midstate_reg;
    assign eng.round2   = round2_reg;
endmodule

// File: tb/tb_sha256_nonce_sequencer.sv
// Bench for sha256_nonce_sequencer: a behavioural SHA-256 block engine plus an
// independent byte-stream double-SHA-256 reference for every nonce of a job.
module tb_sha256_nonce_sequencer;
    localparam int N       = 16;
    localparam int ENG_LAT = 4;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [18:0][31:0] header = '0;
    logic              busy, job_done, out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_nonce, out_hash;

    sha256_nonce_sequencer_if eng_if ();

    sha256_nonce_sequencer #(.NUM_NONCES(N)) dut (
        .clk(clk), .reset(reset), .start(start), .header(header),
        .busy(busy), .job_done(job_done), .out_valid(out_valid), .out_ready(out_ready),
        .out_nonce(out_nonce), .out_hash(out_hash), .eng(eng_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [7:0][31:0] sha_iv();
        logic [7:0][31:0] h;
        h[0] = 32'h6a09e667; h[1] = 32'hbb67ae85; h[2] = 32'h3c6ef372; h[3] = 32'ha54ff53a;
        h[4] = 32'h510e527f; h[5] = 32'h9b05688c; h[6] = 32'h1f83d9ab; h[7] = 32'h5be0cd19;
        return h;
    endfunction

    function automatic logic [7:0][31:0] sha_compress(input logic [7:0][31:0] hin, input logic [15:0][31:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        logic [7:0][31:0] hout;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        a = hin[0]; b = hin[1]; c = hin[2]; d = hin[3]; e = hin[4]; f = hin[5]; g = hin[6]; h = hin[7];
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        hout[0] = hin[0] + a; hout[1] = hin[1] + b; hout[2] = hin[2] + c; hout[3] = hin[3] + d;
        hout[4] = hin[4] + e; hout[5] = hin[5] + f; hout[6] = hin[6] + g; hout[7] = hin[7] + h;
        return hout;
    endfunction

    // Generic SHA-256 of a word-aligned message of n words (n <= 29).
    function automatic logic [7:0][31:0] sha256_words(input logic [31:0] msg [32], input int n);
        logic [31:0] buffer [48];
        logic [15:0][31:0] blk;
        logic [7:0][31:0] h;
        int nblk;
        nblk = (n + 3 + 15) / 16;
        for (int i = 0; i < 48; i++) buffer[i] = (i < n) ? msg[i] : 32'h0;
        buffer[n] = 32'h8000_0000;
        buffer[nblk*16-1] = 32'(n * 32);
        h = sha_iv();
        for (int bi = 0; bi < nblk; bi++) begin
            for (int j = 0; j < 16; j++) blk[j] = buffer[bi*16+j];
            h = sha_compress(h, blk);
        end
        return h;
    endfunction

    function automatic logic [31:0] golden_h0(input logic [18:0][31:0] hdr, input logic [31:0] nonce);
        logic [31:0] msg [32];
        logic [7:0][31:0] d1, d2;
        for (int i = 0; i < 32; i++) msg[i] = 32'h0;
        for (int i = 0; i < 19; i++) msg[i] = hdr[i];
        msg[19] = nonce;
        d1 = sha256_words(msg, 20);
        for (int i = 0; i < 32; i++) msg[i] = (i < 8) ? d1[i] : 32'h0;
        d2 = sha256_words(msg, 8);
        return d2[0];
    endfunction

    // Behavioural engine: fixed latency, result and done presented together.
    logic              m_busy;
    int                m_cnt;
    logic [15:0][31:0] m_msg;
    logic [7:0][31:0]  m_hv;
    logic              m_r2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_cnt <= 0; m_msg <= '0; m_hv <= '0; m_r2 <= 1'b0;
            eng_if.done <= 1'b0; eng_if.result <= '0;
        end else begin
            eng_if.done <= 1'b0;
            if (eng_if.start) begin
                m_busy <= 1'b1; m_cnt <= ENG_LAT;
                m_msg <= eng_if.message; m_hv <= eng_if.hash_val; m_r2 <= eng_if.round2;
            end else if (m_busy) begin
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    eng_if.done <= 1'b1;
                    eng_if.result <= sha_compress(m_r2 ? m_hv : sha_iv(), m_msg);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    typedef struct { logic [15:0][31:0] msg; logic [7:0][31:0] hv; logic r2; } blk_rec_t;
    blk_rec_t         blocks [$];
    logic [7:0][31:0] results [$];
    int               starts_total = 0;

    // Engine-bus monitor: records every block request and checks it holds until done.
    initial begin
        blk_rec_t rec;
        bit active = 0;
        bit bad = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 0;
            end else begin
                if (eng_if.start) begin
                    starts_total++;
                    if (active) bad = 1;
                    else bad = 0;
                    rec.msg = eng_if.message; rec.hv = eng_if.hash_val; rec.r2 = eng_if.round2;
                    blocks.push_back(rec);
                    active = 1;
                end else if (active) begin
                    if (eng_if.message !== rec.msg || eng_if.round2 !== rec.r2 ||
                        (rec.r2 && eng_if.hash_val !== rec.hv)) bad = 1;
                    if (eng_if.done) begin
                        chk($sformatf("blk%0d_hold", blocks.size() - 1), 32'(bad), 32'd0);
                        results.push_back(eng_if.result);
                        active = 0;
                    end
                end
            end
        end
    end

    typedef struct { int blk; int word; logic [31:0] exp; } blkvec_t;
    typedef struct { logic [31:0] nonce; logic [31:0] hash; } resvec_t;
    resvec_t exp_res [N];

    task automatic run_job(input logic [18:0][31:0] hdr, input bit bp, input bit poke_start);
        int got = 0, dones = 0, hold = 0, starts0;
        bit saw_done = 0, finished = 0;
        logic [31:0] sn, sh;
        for (int i = 0; i < N; i++) exp_res[i] = '{32'(i), golden_h0(hdr, 32'(i))};
        blocks.delete(); results.delete();
        starts0 = starts_total;
        @(negedge clk); header = hdr; start = 1'b1; out_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 19; i++) header[i] = 32'hDEAD_0000 | 32'(i);
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            start = (poke_start && cyc == 20);
            if (saw_done) begin
                chk("busy_after_done", 32'(busy), 32'd0);
                finished = 1;
            end
            if (job_done) begin dones++; saw_done = 1; end
            if (out_valid) begin
                if (bp && got == 3 && hold < 5) begin
                    out_ready = 1'b0;
                    if (hold == 0) begin sn = out_nonce; sh = out_hash; end
                    else chkw($sformatf("bp_hold%0d", hold), 512'({out_valid, out_nonce, out_hash}), 512'({1'b1, sn, sh}));
                    hold++;
                    if (hold == 5) chk("bp_no_start", 32'(starts_total - starts0), 32'd9);
                end else begin
                    out_ready = 1'b1;
                    if (got < N) begin
                        chk($sformatf("nonce%0d", got), out_nonce, exp_res[got].nonce);
                        chk($sformatf("hash%0d", got), out_hash, exp_res[got].hash);
                    end
                    got++;
                end
            end
        end
        start = 1'b0;
        if (!finished) chk("job_timeout", 32'd1, 32'd0);
        chk("result_count", 32'(got), 32'(N));
        chk("start_pulses", 32'(starts_total - starts0), 32'(1 + 2 * N));
        chk("job_done_pulses", 32'(dones), 32'd1);
        if (bp) chk("bp_hold_cycles", 32'(hold), 32'd5);
        if (blocks.size() == 1 + 2 * N && results.size() == 1 + 2 * N) begin
            chkw("blk0_msg", 512'(blocks[0].msg), 512'(hdr[15:0]));
            chkw("blk1_midstate", 512'(blocks[1].hv), 512'(results[0]));
            for (int k = 0; k < N; k++) begin
                chk($sformatf("blk%0d_nonce", 2*k+1), blocks[2*k+1].msg[3], 32'(k));
                chkw($sformatf("blk%0d_digest1", 2*k+2), 512'(blocks[2*k+2].msg[7:0]), 512'(results[2*k+1]));
            end
        end else begin
            chk("block_records", 32'(blocks.size()), 32'(1 + 2 * N));
        end
    endtask

    initial begin
        blkvec_t vec [$];
        logic [18:0][31:0] hdr;
        int waited;

        // Constant words of the first three blocks for header[i] = i; word -1 selects round2.
        vec.push_back('{0, 15, 32'h0000_000F}); vec.push_back('{0, 0, 32'h0});
        vec.push_back('{0, -1, 32'd0});
        vec.push_back('{1, 0, 32'd16});         vec.push_back('{1, 1, 32'd17});
        vec.push_back('{1, 2, 32'd18});         vec.push_back('{1, 3, 32'h0});
        vec.push_back('{1, 4, 32'h8000_0000});  vec.push_back('{1, 5, 32'h0});
        vec.push_back('{1, 14, 32'h0});         vec.push_back('{1, 15, 32'h0000_0280});
        vec.push_back('{1, -1, 32'd1});
        vec.push_back('{2, 8, 32'h8000_0000});  vec.push_back('{2, 9, 32'h0});
        vec.push_back('{2, 14, 32'h0});         vec.push_back('{2, 15, 32'h0000_0100});
        vec.push_back('{2, -1, 32'd0});

        repeat (3) @(negedge clk);
        chkw("reset_outputs", 512'({busy, job_done, out_valid, out_nonce, out_hash, eng_if.start, eng_if.round2}), 512'(0));
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chkw($sformatf("idle%0d", c), 512'({busy, job_done, out_valid, out_nonce, out_hash, eng_if.start,
                                                 eng_if.round2, eng_if.message, eng_if.hash_val}), 512'(0));
        end
        chk("idle_no_start", 32'(starts_total), 32'd0);

        // Job A: header[i] = i, free-flowing output, stray start mid-job.
        for (int i = 0; i < 19; i++) hdr[i] = 32'(i);
        run_job(hdr, 1'b0, 1'b1);
        if (blocks.size() >= 3) begin
            foreach (vec[v]) begin
                if (vec[v].word < 0)
                    chk($sformatf("blk%0d_round2", vec[v].blk), 32'(blocks[vec[v].blk].r2), vec[v].exp);
                else
                    chk($sformatf("blk%0d_w%0d", vec[v].blk, vec[v].word), blocks[vec[v].blk].msg[vec[v].word], vec[v].exp);
            end
        end

        // Job B: different header, backpressure on the fourth result.
        for (int i = 0; i < 19; i++) hdr[i] = 32'(i + 1) * 32'h9E37_79B9;
        run_job(hdr, 1'b1, 1'b0);

        // Job C aborted by reset while the second block is in flight.
        for (int i = 0; i < 19; i++) hdr[i] = 32'h0BAD_F00D ^ 32'(i);
        waited = starts_total;
        @(negedge clk); header = hdr; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 200 && starts_total - waited < 2; c++) @(negedge clk);
        chk("abort_reached_b2", 32'(starts_total - waited), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chkw("abort_outputs", 512'({busy, job_done, out_valid, out_nonce, out_hash, eng_if.start, eng_if.round2}), 512'(0));
        chkw("abort_message", 512'(eng_if.message), 512'(0));
        chkw("abort_hash_val", 512'(eng_if.hash_val), 512'(0));
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        waited = starts_total;
        repeat (3) @(negedge clk);
        chk("post_abort_idle", 32'({busy, out_valid}), 32'd0);
        chk("post_abort_no_start", 32'(starts_total - waited), 32'd0);

        // Job D: fresh start after the abort recomputes midstate and restarts at nonce 0.
        for (int i = 0; i < 19; i++) hdr[i] = 32'hA5A5_0000 ^ (32'(i) << 3);
        run_job(hdr, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
